// File: rtl/stack.sv
// Synchronous LIFO stack with registered pop data and combinational full/empty flags.
// Push and pop in the same cycle on a non-empty stack swaps the top entry.
module stack #(
    parameter int WIDTH = 8,
    parameter int DEPTH = 8,
    parameter int PTR_W = $clog2(DEPTH) + 1
) (
    input  logic             clk,
    input  logic             rstn,
    input  logic             push,
    input  logic             pop,
    input  logic [WIDTH-1:0] din,
    output logic [WIDTH-1:0] dout,
    output logic             empty,
    output logic             full
);

    localparam int AW = PTR_W - 1;

    logic [WIDTH-1:0] r_mem [DEPTH];
    logic [PTR_W-1:0] r_sp;
    logic [WIDTH-1:0] r_dout;

    logic             w_empty;
    logic             w_full;
    logic             w_swap;
    logic             w_push;
    logic             w_pop;
    logic [AW-1:0]    w_wr_idx;
    logic [AW-1:0]    w_top_idx;

    // Push+pop on an empty stack degrades to a plain push.
    always_comb begin
        w_empty   = (r_sp == '0);
        w_full    = (r_sp == PTR_W'(DEPTH));
        w_swap    = push && pop && !w_empty;
        w_push    = push && !w_full && !w_swap;
        w_pop     = pop && !push && !w_empty;
        w_wr_idx  = r_sp[AW-1:0];
        w_top_idx = AW'(r_sp - PTR_W'(1));
    end

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            r_sp   <= '0;
            r_dout <= '0;
            for (int i = 0; i < DEPTH; i++) begin
                r_mem[i] <= '0;
            end
        end else begin
            if (w_push) begin
                r_mem[w_wr_idx] <= din;
                r_sp            <= r_sp + PTR_W'(1);
            end else if (w_pop) begin
                r_dout <= r_mem[w_top_idx];
                r_sp   <= r_sp - PTR_W'(1);
            end else if (w_swap) begin
                r_dout           <= r_mem[w_top_idx];
                r_mem[w_top_idx] <= din;
            end
        end
    end

    assign dout  = r_dout;
    assign empty = w_empty;
    assign full  = w_full;

endmodule

// File: tb/tb_stack.sv
// Bench for stack: directed checks with literal expectations plus randomized traffic,
// all compared every cycle against a queue-based LIFO model.
module tb_stack;

    localparam int WIDTH = 8;
    localparam int DEPTH = 8;

    logic             clk;
    logic             rstn;
    logic             push;
    logic             pop;
    logic [WIDTH-1:0] din;
    logic [WIDTH-1:0] dout;
    logic             empty;
    logic             full;

    stack #(.WIDTH(WIDTH), .DEPTH(DEPTH)) dut (
        .clk   (clk),
        .rstn  (rstn),
        .push  (push),
        .pop   (pop),
        .din   (din),
        .dout  (dout),
        .empty (empty),
        .full  (full)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int               total = 0;
    int               bad   = 0;
    bit               chk_en = 1'b0;
    logic [WIDTH-1:0] q [$];
    logic [WIDTH-1:0] exp_dout;

    function automatic void check(string name, logic [31:0] act, logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endfunction

    // Every-cycle comparison against the model, away from the active edge.
    always @(negedge clk) begin
        if (chk_en) begin
            check("cyc_dout", 32'(dout), 32'(exp_dout));
            check("cyc_empty", 32'(empty), 32'(q.size() == 0));
            check("cyc_full", 32'(full), 32'(q.size() == DEPTH));
        end
    end

    task automatic model_reset();
        q.delete();
        exp_dout = '0;
    endtask

    task automatic model_step(input bit p, input bit o, input logic [WIDTH-1:0] d);
        if (p && o && q.size() > 0) begin
            exp_dout      = q[q.size()-1];
            q[q.size()-1] = d;
        end else if (p && q.size() < DEPTH) begin
            q.push_back(d);
        end else if (o && !p && q.size() > 0) begin
            exp_dout = q.pop_back();
        end
    endtask

    // One operation; returns 1 ns after the sampling edge with inputs idled.
    task automatic op(input bit p, input bit o, input logic [WIDTH-1:0] d);
        @(negedge clk);
        #1;
        push = p;
        pop  = o;
        din  = d;
        model_step(p, o, d);
        @(posedge clk);
        #1;
        push = 1'b0;
        pop  = 1'b0;
    endtask

    task automatic sync_reset(input int cycles);
        @(negedge clk);
        #1;
        rstn = 1'b0;
        model_reset();
        repeat (cycles) @(posedge clk);
        @(negedge clk);
        #1;
        rstn = 1'b1;
    endtask

    logic [WIDTH-1:0] fill_v [8];
    int               n_push;
    int               n_pop;

    initial begin
        fill_v = '{8'h11, 8'h22, 8'h33, 8'h44, 8'h11, 8'h22, 8'h33, 8'h44};
        rstn = 1'b1;
        push = 1'b0;
        pop  = 1'b0;
        din  = '0;
        exp_dout = '0;
        #1;
        rstn = 1'b0;
        model_reset();
        #1;
        chk_en = 1'b1;
        repeat (3) @(posedge clk);
        #1;
        check("rst_dout", 32'(dout), 32'h00);
        check("rst_empty", 32'(empty), 32'd1);
        check("rst_full", 32'(full), 32'd0);
        @(negedge clk);
        #1;
        rstn = 1'b1;

        // Fill
        for (int i = 0; i < 8; i++) begin
            op(1'b1, 1'b0, fill_v[i]);
            if (i == 0) check("fill_empty_drop", 32'(empty), 32'd0);
            if (i == 6) check("fill_not_full_7", 32'(full), 32'd0);
            check("fill_dout_hold", 32'(dout), 32'h00);
        end
        check("fill_full_8", 32'(full), 32'd1);

        // Pop and refill
        op(1'b0, 1'b1, '0);
        check("pop_44", 32'(dout), 32'h44);
        check("pop_full_clr", 32'(full), 32'd0);
        op(1'b0, 1'b1, '0);
        check("pop_33", 32'(dout), 32'h33);
        op(1'b1, 1'b0, 8'hAA);
        op(1'b1, 1'b0, 8'hBB);
        check("refill_full", 32'(full), 32'd1);
        op(1'b0, 1'b1, '0);
        check("pop_BB", 32'(dout), 32'hBB);
        check("pop_BB_full", 32'(full), 32'd0);

        // Overflow: push while full is dropped
        op(1'b1, 1'b0, 8'hBB);
        op(1'b1, 1'b0, 8'h55);
        check("ovf_full_held", 32'(full), 32'd1);
        check("ovf_model_cnt", 32'(q.size()), 32'd8);
        op(1'b0, 1'b1, '0);
        check("ovf_pop_prior", 32'(dout), 32'hBB);

        // Underflow
        sync_reset(1);
        for (int i = 0; i < 8; i++) op(1'b1, 1'b0, fill_v[i]);
        for (int i = 0; i < 8; i++) begin
            op(1'b0, 1'b1, '0);
            check("unf_pop_seq", 32'(dout), 32'(fill_v[7-i]));
        end
        check("unf_empty", 32'(empty), 32'd1);
        op(1'b0, 1'b1, '0);
        check("unf_9th_dout", 32'(dout), 32'h11);
        check("unf_9th_empty", 32'(empty), 32'd1);

        // Swap-top
        op(1'b1, 1'b0, 8'h11);
        op(1'b1, 1'b0, 8'h22);
        op(1'b1, 1'b0, 8'h33);
        op(1'b1, 1'b1, 8'h77);
        check("swap_dout", 32'(dout), 32'h33);
        check("swap_cnt", 32'(q.size()), 32'd3);
        op(1'b0, 1'b1, '0);
        check("swap_pop_77", 32'(dout), 32'h77);
        op(1'b0, 1'b1, '0);
        op(1'b0, 1'b1, '0);
        check("swap_drain_11", 32'(dout), 32'h11);
        op(1'b1, 1'b1, 8'h66);
        check("swap_empty_push", 32'(empty), 32'd0);
        check("swap_empty_dout", 32'(dout), 32'h11);
        op(1'b0, 1'b1, '0);
        check("swap_empty_pop66", 32'(dout), 32'h66);

        // Mid-operation asynchronous reset with 5 entries
        for (int i = 0; i < 5; i++) op(1'b1, 1'b0, 8'(8'hC0 + i));
        op(1'b0, 1'b1, '0);
        op(1'b1, 1'b0, 8'hD5);
        check("mid_cnt5", 32'(q.size()), 32'd5);
        @(posedge clk);
        #3;
        rstn = 1'b0;
        model_reset();
        #1;
        check("async_dout", 32'(dout), 32'h00);
        check("async_empty", 32'(empty), 32'd1);
        check("async_full", 32'(full), 32'd0);
        @(negedge clk);
        #1;
        rstn = 1'b1;

        // Randomized traffic with varying push/pop bias
        for (int phase = 0; phase < 4; phase++) begin
            n_push = (phase == 0) ? 80 : (phase == 1) ? 20 : 50;
            n_pop  = (phase == 2) ? 80 : 50;
            for (int i = 0; i < 150; i++) begin
                op(($urandom_range(99) < n_push), ($urandom_range(99) < n_pop),
                   WIDTH'($urandom));
            end
        end

        @(negedge clk);
        #1;
        chk_en = 1'b0;
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/stack.md
Name: stack

Overview:
- Synchronous LIFO stack, parameterised width and depth; one push or pop (or both) per clock.
- Used as local last-in-first-out storage between a producer and a consumer in the same clock domain.
- Exposes `full` and `empty` status flags and a registered read-data output.

Parameters:
- WIDTH, 8, data word width in bits.
- DEPTH, 8, number of entries; must be ≥ 2.
- PTR_W, $clog2(DEPTH)+1, stack-pointer width; derived, must not be overridden.

Ports:
- clk  input  1  clock; all state changes on the rising edge.
- rstn  input  1  asynchronous, active-low reset.
- push  input  1  write request; `din` is sampled on the same edge.
- pop  input  1  read request.
- din  input  WIDTH  data to push.
- dout  output  WIDTH  registered data of the last successful pop.
- empty  output  1  high when the stack holds 0 entries.
- full  output  1  high when the stack holds DEPTH entries.

Behaviour:
- Reset: one clock; reset is asynchronous and active-low (`rstn`), clock is `clk`.
- While `rstn`=0: sp=0, dout=0, all memory entries=0, empty=1, full=0. Reset is applied immediately, independent of `clk`.
- Release of reset is synchronous to the next rising edge; any operation in flight is discarded.
- State: storage mem[0..DEPTH-1]; pointer sp = count of stored entries. The top entry is mem[sp-1].
- Flags: empty = (sp==0) and full = (sp==DEPTH). Both are decoded combinationally from the sp register, so they update in the same cycle as sp.
- Push only (push=1, pop=0, full=0): mem[sp] ← din; sp ← sp+1; dout unchanged.
- Push when full: ignored; sp, memory and dout unchanged; no overwrite.
- Pop only (pop=1, push=0, empty=0): dout ← mem[sp-1]; sp ← sp-1.
  - Latency is 1 clock: popped data is valid on `dout` after the same rising edge that samples `pop`.
  - The vacated entry keeps its old content; it is not cleared.
- Pop when empty: ignored; dout holds its previous value; sp stays 0.
- push=1 and pop=1, not empty: swap-top.
  - dout ← mem[sp-1]; mem[sp-1] ← din; sp unchanged.
  - Legal when full; flags unchanged.
- push=1 and pop=1, empty: treated as push only; dout unchanged; sp ← 1.
- dout holds its value indefinitely between pops.
- No error/overflow output; illegal requests are silently dropped.
- Requests are level-sampled per edge: a request held N cycles performs N operations.

Test Plan:
- Reset: rstn=0 for 3 cycles with push=pop=0 → empty=1, full=0, dout=00. Assert rstn=0 mid-operation with sp=5 → sp=0, empty=1, dout=00 immediately.
- Fill: after reset, single-cycle pushes of 11,22,33,44,11,22,33,44 → empty drops after the 1st push; full=1 only after the 8th push; dout stays 00 throughout.
- Pop and refill:
  - From full, pop → dout=44, full=0.
  - Pop → dout=33.
  - Push AA, then push BB → full=1.
  - Pop → dout=BB, full=0.
- Overflow: from full, push 55 → ignored; the next pop returns the prior top (not 55); sp count unchanged before the pop.
- Underflow: pop 8 times from the fill state → dout sequence 44,33,22,11,44,33,22,11, empty=1. A 9th pop → dout remains 11, empty stays 1.
- Simultaneous operations:
  - With 3 entries (11,22,33), push=pop=1 with din=77 → dout=33, count stays 3; the next pop → dout=77.
  - When empty, push=pop=1 with din=66 → empty=0, dout unchanged; the next pop → dout=66.
